// File: rtl/countdown_timer.sv
// BCD MM:SS countdown engine: loads a clamped start value, decrements once per
// accepted seconds tick while running, and flags expiry at 00:00.
module countdown_timer #(
  parameter int WARN_SECS = 10
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [3:0] ld_mt,
  input  logic [3:0] ld_mo,
  input  logic [3:0] ld_st,
  input  logic [3:0] ld_so,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] mt,
  output logic [3:0] mo,
  output logic [3:0] st,
  output logic [3:0] so,
  output logic       running,
  output logic       paused,
  output logic       expired,
  output logic       done_pulse,
  output logic       warn
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_time_t;

  localparam logic [12:0] WARN_LIM = 13'(WARN_SECS);

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Ripple borrow from seconds-ones up to minutes-tens.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.so != 4'd0) begin
      r.so = t.so - 4'd1;
    end else begin
      r.so = 4'd9;
      if (t.st != 4'd0) begin
        r.st = t.st - 4'd1;
      end else begin
        r.st = 4'd5;
        if (t.mo != 4'd0) begin
          r.mo = t.mo - 4'd1;
        end else begin
          r.mo = 4'd9;
          r.mt = t.mt - 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [12:0] to_secs(input bcd_time_t t);
    logic [12:0] minutes;
    minutes = {9'd0, t.mt} * 13'd10 + {9'd0, t.mo};
    return minutes * 13'd60 + {9'd0, t.st} * 13'd10 + {9'd0, t.so};
  endfunction

  state_t      state_q, state_d;
  bcd_time_t   time_q, time_d;
  bcd_time_t   time_dec;
  bcd_time_t   load_val;
  logic        done_d;
  logic [12:0] remaining;

  always_comb begin
    load_val.mt = clamp_digit(ld_mt, 4'd9);
    load_val.mo = clamp_digit(ld_mo, 4'd9);
    load_val.st = clamp_digit(ld_st, 4'd5);
    load_val.so = clamp_digit(ld_so, 4'd9);
  end

  assign time_dec = bcd_dec(time_q);

  // NOTE: every output of this block gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = IDLE;
      time_d  = load_val;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A 00:00 value cannot start; it must not fake an expiry either.
          if (start && (time_q != '0)) state_d = RUN;
        end
        RUN: begin
          // Pause outranks tick, so a tick in the pause cycle is dropped.
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            time_d = time_dec;
            if (time_dec == '0) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start) state_d = RUN;
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      time_q     <= '0;
      running    <= 1'b0;
      paused     <= 1'b0;
      expired    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      running    <= (state_d == RUN);
      paused     <= (state_d == PAUSE);
      expired    <= (state_d == EXPIRED);
      done_pulse <= done_d;
    end
  end

  assign mt = time_q.mt;
  assign mo = time_q.mo;
  assign st = time_q.st;
  assign so = time_q.so;

  // warn is decoded from registered state and digits only.
  assign remaining = to_secs(time_q);
  assign warn      = (running || paused) && (remaining != 13'd0) && (remaining <= WARN_LIM);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// stimulus, all compared against a total-seconds reference model.
module tb_countdown_timer;

  localparam int WARN = 10;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic       tick   = 1'b0;
  logic       load   = 1'b0;
  logic       start  = 1'b0;
  logic       pause  = 1'b0;
  logic [3:0] ld_mt  = '0;
  logic [3:0] ld_mo  = '0;
  logic [3:0] ld_st  = '0;
  logic [3:0] ld_so  = '0;
  logic [3:0] mt, mo, st, so;
  logic       running, paused, expired, done_pulse, warn;

  countdown_timer #(.WARN_SECS(WARN)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .tick       (tick),
    .load       (load),
    .ld_mt      (ld_mt),
    .ld_mo      (ld_mo),
    .ld_st      (ld_st),
    .ld_so      (ld_so),
    .start      (start),
    .pause      (pause),
    .mt         (mt),
    .mo         (mo),
    .st         (st),
    .so         (so),
    .running    (running),
    .paused     (paused),
    .expired    (expired),
    .done_pulse (done_pulse),
    .warn       (warn)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} m_state_t;
  m_state_t m_state = M_IDLE;
  int       m_secs  = 0;
  bit       m_done  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] secs_to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic int clamp(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [15:0] digits();
    return {mt, mo, st, so};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_secs  = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_step(input bit l, input bit s, input bit p, input bit t,
                            input int a, input int b, input int c, input int d);
    m_done = 1'b0;
    if (l) begin
      m_state = M_IDLE;
      m_secs  = (clamp(a, 9) * 10 + clamp(b, 9)) * 60 + clamp(c, 5) * 10 + clamp(d, 9);
    end else begin
      case (m_state)
        M_IDLE:  if (s && m_secs != 0) m_state = M_RUN;
        M_RUN: begin
          if (p) m_state = M_PAUSE;
          else if (t) begin
            m_secs--;
            if (m_secs == 0) begin
              m_state = M_EXP;
              m_done  = 1'b1;
            end
          end
        end
        M_PAUSE: if (s) m_state = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    bit w;
    w = (m_state == M_RUN || m_state == M_PAUSE) && m_secs > 0 && m_secs <= WARN;
    check("digits",     32'(digits()),     32'(secs_to_bcd(m_secs)));
    check("running",    32'(running),      32'(m_state == M_RUN));
    check("paused",     32'(paused),       32'(m_state == M_PAUSE));
    check("expired",    32'(expired),      32'(m_state == M_EXP));
    check("done_pulse", 32'(done_pulse),   32'(m_done));
    check("warn",       32'(warn),         32'(w));
  endtask

  task automatic cycle(input bit l, input bit s, input bit p, input bit t,
                       input logic [3:0] a = 0, input logic [3:0] b = 0,
                       input logic [3:0] c = 0, input logic [3:0] d = 0);
    @(negedge clk_in);
    load = l; start = s; pause = p; tick = t;
    ld_mt = a; ld_mo = b; ld_st = c; ld_so = d;
    @(posedge clk_in);
    model_step(l, s, p, t, int'(a), int'(b), int'(c), int'(d));
    #1 compare_all();
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, a, b, c, d);
  endtask

  task automatic do_start(); cycle(1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_tick();  cycle(1'b0, 1'b0, 1'b0, 1'b1); endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  initial begin
    #3 model_reset();
    compare_all();
    @(negedge clk_in);
    reset = 1'b1;

    // Expire from 00:03 with spaced ticks, then a stray tick after expiry.
    do_load(0, 0, 0, 3);
    do_start();
    for (int i = 0; i < 3; i++) begin
      do_tick();
      idle_n(4);
    end
    check("expired_hold", 32'(expired), 32'd1);
    do_tick();
    check("expired_digits", 32'(digits()), 32'h0000);

    // Full borrow chain.
    do_load(1, 0, 0, 0);
    do_start();
    do_tick();
    check("borrow_1000", 32'(digits()), 32'h0959);
    do_load(0, 1, 0, 0);
    do_start();
    do_tick();
    check("borrow_0100", 32'(digits()), 32'h0059);

    // Warn window from 00:20 down to expiry.
    do_load(0, 0, 2, 0);
    do_start();
    for (int i = 0; i < 20; i++) do_tick();
    check("warn_expired", 32'(warn), 32'd0);

    // Pause/resume with coincident ticks.
    do_load(0, 5, 0, 0);
    do_start();
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("pause_hold", 32'(digits()), 32'h0500);
    for (int i = 0; i < 3; i++) do_tick();
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("resume_hold", 32'(digits()), 32'h0500);
    do_tick();
    check("resume_tick", 32'(digits()), 32'h0459);

    // Clamping, and start refused at 00:00.
    do_load(3, 0, 7, 12);
    check("clamp", 32'(digits()), 32'h3059);
    do_load(0, 0, 0, 0);
    do_start();
    check("start_zero", 32'(running), 32'd0);

    // Load wins over an expiry-causing tick.
    do_load(0, 0, 0, 1);
    do_start();
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 0, 0);
    check("load_wins", 32'(digits()), 32'h0200);

    // Asynchronous reset in the middle of a run.
    do_start();
    do_tick();
    do_reset();
    idle_n(2);

    // Random phase; small loads are favoured so expiry happens often.
    for (int i = 0; i < 4000; i++) begin
      bit l, s, p, t;
      logic [3:0] a, b, c, d;
      l = ($urandom_range(99) < 3);
      s = ($urandom_range(99) < 12);
      p = ($urandom_range(99) < 6);
      t = ($urandom_range(99) < 60);
      if ($urandom_range(1) == 0) begin
        a = 0; b = 0; c = 4'($urandom_range(2)); d = 4'($urandom_range(15));
      end else begin
        a = 4'($urandom_range(15)); b = 4'($urandom_range(15));
        c = 4'($urandom_range(15)); d = 4'($urandom_range(15));
      end
      if ($urandom_range(999) == 0) do_reset();
      else cycle(l, s, p, t, a, b, c, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
